// File: rtl/complex_nr_pkg.sv
// rtl/complex_nr_pkg.sv - shared widths and FSM state encoding for the complex MAC accumulator
// Purpose : default operand/product widths and the two-state encoding used by complex_nr_acc.
// Ports   : none (package).
package complex_nr_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int RES_WIDTH_DEF  = 2 * DATA_WIDTH_DEF + 1;
    localparam int LEN_WIDTH_DEF  = 6;
    localparam int ACC_WIDTH_DEF  = RES_WIDTH_DEF + LEN_WIDTH_DEF;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

endpackage

// File: rtl/complex_nr_acc_if.sv
// rtl/complex_nr_acc_if.sv - product input and frame-sum output handshakes
// Purpose : bundles the res_* product channel and the acc_* sum channel.
// Ports   : slave  - the accumulator (takes products, presents sums)
//           master - the surrounding logic (multiplier side + consumer side)
interface complex_nr_acc_if
    import complex_nr_pkg::*;
#(
    parameter int RES_WIDTH = RES_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) ();

    logic                        res_val;
    logic                        res_ready;
    logic signed [RES_WIDTH-1:0] res_re;
    logic signed [RES_WIDTH-1:0] res_im;

    logic                        acc_val;
    logic                        acc_ready;
    logic signed [ACC_WIDTH-1:0] acc_re;
    logic signed [ACC_WIDTH-1:0] acc_im;
    logic                        acc_ovf;

    modport slave (
        input  res_val, res_re, res_im, acc_ready,
        output res_ready, acc_val, acc_re, acc_im, acc_ovf
    );

    modport master (
        output res_val, res_re, res_im, acc_ready,
        input  res_ready, acc_val, acc_re, acc_im, acc_ovf
    );

endinterface

// File: rtl/complex_nr_acc_add.sv
// rtl/complex_nr_acc_add.sv - signed wrapping adder with overflow flag
// Purpose : one component (re or im) of the accumulator addition.
// Ports   : i_a, i_b - signed addends
//           o_sum    - two's-complement wrapped sum
//           o_ovf    - signed overflow of this addition
module complex_nr_acc_add
    import complex_nr_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic signed [ACC_WIDTH-1:0] i_a,
    input  logic signed [ACC_WIDTH-1:0] i_b,
    output logic signed [ACC_WIDTH-1:0] o_sum,
    output logic                        o_ovf
);

    assign o_sum = i_a + i_b;

    // Overflow only possible when both addends share a sign and the result flips it.
    assign o_ovf = (i_a[ACC_WIDTH-1] == i_b[ACC_WIDTH-1]) &&
                   (o_sum[ACC_WIDTH-1] != i_a[ACC_WIDTH-1]);

endmodule

// File: rtl/complex_nr_acc.sv
// rtl/complex_nr_acc.sv - frame accumulator turning the complex multiplier into a MAC stage
// Purpose : sums cfg_len complex products per frame and presents the sum with an overflow flag.
// Ports   : clk       - rising-edge clock
//           sw_rst    - synchronous active-high reset
//           cfg_len   - products per frame (0 means 1), sampled on the first product
//           frame_cnt - products accepted in the current frame
//           bus       - res_* product handshake in, acc_* sum handshake out
module complex_nr_acc
    import complex_nr_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RES_WIDTH  = 2 * DATA_WIDTH + 1,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int ACC_WIDTH  = RES_WIDTH + LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 sw_rst,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    output logic [LEN_WIDTH-1:0] frame_cnt,
    complex_nr_acc_if.slave      bus
);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [LEN_WIDTH-1:0]        r_len;
    logic [LEN_WIDTH-1:0]        r_cnt;
    logic [LEN_WIDTH-1:0]        w_cnt_inc;
    logic [LEN_WIDTH-1:0]        w_len_eff;
    logic [LEN_WIDTH-1:0]        w_len_cur;
    logic signed [ACC_WIDTH-1:0] r_acc_re;
    logic signed [ACC_WIDTH-1:0] r_acc_im;
    logic signed [ACC_WIDTH-1:0] w_prod_re;
    logic signed [ACC_WIDTH-1:0] w_prod_im;
    logic signed [ACC_WIDTH-1:0] w_sum_re;
    logic signed [ACC_WIDTH-1:0] w_sum_im;
    logic                        r_ovf;
    logic                        w_ovf_re;
    logic                        w_ovf_im;
    logic                        w_ready;
    logic                        w_xfer;
    logic                        w_first;
    logic                        w_last;

    // Ready comes from state only; it is also held low while reset is asserted.
    assign w_ready = (r_state == ST_ACC) && !sw_rst;
    assign w_xfer  = bus.res_val && w_ready;

    assign w_prod_re = {{(ACC_WIDTH-RES_WIDTH){bus.res_re[RES_WIDTH-1]}}, bus.res_re};
    assign w_prod_im = {{(ACC_WIDTH-RES_WIDTH){bus.res_im[RES_WIDTH-1]}}, bus.res_im};

    // The first product of a frame latches the length, so the end-of-frame test
    // must use the freshly computed length on that same cycle.
    assign w_first   = (r_cnt == '0);
    assign w_len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    assign w_len_cur = w_first ? w_len_eff : r_len;
    assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);
    assign w_last    = (w_cnt_inc == w_len_cur);

    complex_nr_acc_add #(.ACC_WIDTH(ACC_WIDTH)) u_add_re (
        .i_a   (r_acc_re),
        .i_b   (w_prod_re),
        .o_sum (w_sum_re),
        .o_ovf (w_ovf_re)
    );

    complex_nr_acc_add #(.ACC_WIDTH(ACC_WIDTH)) u_add_im (
        .i_a   (r_acc_im),
        .i_b   (w_prod_im),
        .o_sum (w_sum_im),
        .o_ovf (w_ovf_im)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC: if (w_xfer && w_last) w_state_nxt = ST_OUT;
            ST_OUT: if (bus.acc_ready)    w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_state  <= ST_ACC;
            r_len    <= LEN_WIDTH'(1);
            r_cnt    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_cnt <= w_cnt_inc;
                if (w_first) begin
                    r_len    <= w_len_eff;
                    r_acc_re <= w_prod_re;
                    r_acc_im <= w_prod_im;
                    r_ovf    <= 1'b0;
                end else begin
                    r_acc_re <= w_sum_re;
                    r_acc_im <= w_sum_im;
                    r_ovf    <= r_ovf || w_ovf_re || w_ovf_im;
                end
            end else if ((r_state == ST_OUT) && bus.acc_ready) begin
                r_cnt <= '0;
            end
        end
    end

    assign bus.res_ready = w_ready;
    assign bus.acc_val   = (r_state == ST_OUT);
    assign bus.acc_re    = r_acc_re;
    assign bus.acc_im    = r_acc_im;
    assign bus.acc_ovf   = r_ovf;
    assign frame_cnt     = r_cnt;

endmodule

// File: tb/tb_complex_nr_acc.sv
// tb/tb_complex_nr_acc.sv - self-checking bench for complex_nr_acc
module tb_complex_nr_acc;

    localparam int RW = 17;
    localparam int AW = 23;
    localparam int LW = 6;
    localparam longint AMAX = (64'sd1 <<< (AW-1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (AW-1));

    logic          clk = 1'b0;
    logic          sw_rst;
    logic [LW-1:0] cfg_len;
    logic [LW-1:0] frame_cnt;

    always #5 clk = ~clk;

    complex_nr_acc_if #(.RES_WIDTH(RW), .ACC_WIDTH(AW)) bus ();

    complex_nr_acc #(
        .DATA_WIDTH (8),
        .RES_WIDTH  (RW),
        .LEN_WIDTH  (LW),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk       (clk),
        .sw_rst    (sw_rst),
        .cfg_len   (cfg_len),
        .frame_cnt (frame_cnt),
        .bus       (bus)
    );

    logic signed [AW-1:0] ta, tb_b, ts;
    logic                 tovf;

    complex_nr_acc_add #(.ACC_WIDTH(AW)) u_add (
        .i_a   (ta),
        .i_b   (tb_b),
        .o_sum (ts),
        .o_ovf (tovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer frame sum, wrapped to AW bits after each add.
    function automatic longint wrap(input longint v);
        longint m;
        m = v & ((64'sd1 <<< AW) - 1);
        if (m > AMAX) m = m - (64'sd1 <<< AW);
        return m;
    endfunction

    function automatic bit add_ovf(input longint a, input longint p);
        return (a + p > AMAX) || (a + p < AMIN);
    endfunction

    bit     m_on  = 1'b0;
    bit     m_out = 1'b0;
    int     m_cnt = 0;
    int     m_len = 1;
    longint m_re  = 0;
    longint m_im  = 0;
    bit     m_ovf = 1'b0;
    longint pr, pi;

    always @(negedge clk) begin
        if (m_on) begin
            chk("res_ready", {63'd0, bus.res_ready}, {63'd0, (!m_out && !sw_rst)});
            chk("acc_val", {63'd0, bus.acc_val}, {63'd0, m_out});
            chk("frame_cnt", {58'd0, frame_cnt}, m_cnt);
            chk("acc_re", bus.acc_re, m_re);
            chk("acc_im", bus.acc_im, m_im);
            if (m_out) chk("acc_ovf", {63'd0, bus.acc_ovf}, {63'd0, m_ovf});
        end
        if (sw_rst) begin
            m_on = 1'b1; m_out = 1'b0; m_cnt = 0;
            m_re = 0; m_im = 0; m_ovf = 1'b0;
        end else if (m_on) begin
            if (!m_out && bus.res_val) begin
                pr = longint'(bus.res_re);
                pi = longint'(bus.res_im);
                if (m_cnt == 0) begin
                    m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
                    m_re = pr; m_im = pi; m_ovf = 1'b0;
                end else begin
                    m_ovf = m_ovf | add_ovf(m_re, pr) | add_ovf(m_im, pi);
                    m_re = wrap(m_re + pr);
                    m_im = wrap(m_im + pi);
                end
                m_cnt++;
                if (m_cnt == m_len) m_out = 1'b1;
            end else if (m_out && bus.acc_ready) begin
                m_out = 1'b0;
                m_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int im);
        bus.res_val = 1'b1;
        bus.res_re  = RW'(re);
        bus.res_im  = RW'(im);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.res_ready) begin
                tick();
                bus.res_val = 1'b0;
                return;
            end
            tick();
        end
        chk("send_timeout", 0, 1);
        bus.res_val = 1'b0;
    endtask

    task automatic drain();
        bus.acc_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.acc_val) begin
                tick();
                bus.acc_ready = 1'b0;
                return;
            end
            tick();
        end
        chk("drain_timeout", 0, 1);
        bus.acc_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    bit last_acc;

    initial begin
        sw_rst = 1'b1; cfg_len = '0;
        bus.res_val = 1'b0; bus.res_re = '0; bus.res_im = '0; bus.acc_ready = 1'b0;

        // adder unit: wrap and overflow at the extremes
        ta = 23'sd4194303; tb_b = 23'sd1; #1;
        chk("add_pos_wrap", ts, -64'sd4194304);
        chk("add_pos_ovf", {63'd0, tovf}, 1);
        ta = -23'sd4194304; tb_b = -23'sd1; #1;
        chk("add_neg_ovf", {63'd0, tovf}, 1);
        ta = 23'sd5; tb_b = -23'sd3; #1;
        chk("add_mixed", ts, 2);
        chk("add_mixed_ovf", {63'd0, tovf}, 0);

        tick();
        @(negedge clk);
        chk("rst_ready", {63'd0, bus.res_ready}, 0);
        tick();
        sw_rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, bus.res_ready}, 1);
        chk("post_rst_val", {63'd0, bus.acc_val}, 0);
        chk("post_rst_cnt", {58'd0, frame_cnt}, 0);
        chk("post_rst_re", bus.acc_re, 0);
        tick();

        // single-product frame
        cfg_len = 6'd1;
        send(-10, 20);
        @(negedge clk);
        chk("f1_val", {63'd0, bus.acc_val}, 1);
        chk("f1_re", bus.acc_re, -10);
        chk("f1_im", bus.acc_im, 20);
        chk("f1_ovf", {63'd0, bus.acc_ovf}, 0);
        chk("f1_cnt", {58'd0, frame_cnt}, 1);
        tick();
        drain();

        // three back-to-back products with consumer ready
        cfg_len = 6'd3;
        bus.acc_ready = 1'b1;
        send(-10, 20); send(-10, 20); send(-10, 20);
        @(negedge clk);
        chk("f3_val", {63'd0, bus.acc_val}, 1);
        chk("f3_re", bus.acc_re, -30);
        chk("f3_im", bus.acc_im, 60);
        tick();
        bus.acc_ready = 1'b0;
        @(negedge clk);
        chk("f3_done_val", {63'd0, bus.acc_val}, 0);
        chk("f3_done_cnt", {58'd0, frame_cnt}, 0);
        tick();

        // backpressure while the sum is pending
        cfg_len = 6'd1;
        send(1, 2);
        bus.res_val = 1'b1; bus.res_re = RW'(7); bus.res_im = RW'(7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", {63'd0, bus.res_ready}, 0);
            chk("bp_val", {63'd0, bus.acc_val}, 1);
            chk("bp_re", bus.acc_re, 1);
            tick();
        end
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_ready", {63'd0, bus.res_ready}, 1);
        tick();
        bus.res_val = 1'b0;
        @(negedge clk);
        chk("bp_next_val", {63'd0, bus.acc_val}, 1);
        chk("bp_next_re", bus.acc_re, 7);
        tick();
        drain();

        // cfg_len of zero behaves as one
        cfg_len = 6'd0;
        send(5, -5);
        @(negedge clk);
        chk("len0_val", {63'd0, bus.acc_val}, 1);
        chk("len0_re", bus.acc_re, 5);
        chk("len0_im", bus.acc_im, -5);
        tick();
        drain();

        // longest frame at extreme products
        cfg_len = 6'd63;
        for (int i = 0; i < 63; i++) send(32767, -32768);
        @(negedge clk);
        chk("f63_val", {63'd0, bus.acc_val}, 1);
        chk("f63_re", bus.acc_re, 2064321);
        chk("f63_im", bus.acc_im, -2064384);
        chk("f63_ovf", {63'd0, bus.acc_ovf}, 0);
        tick();
        drain();

        // reset mid-frame discards the partial sum
        cfg_len = 6'd3;
        send(9, 9); send(9, 9);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        @(negedge clk);
        chk("mrst_val", {63'd0, bus.acc_val}, 0);
        chk("mrst_cnt", {58'd0, frame_cnt}, 0);
        chk("mrst_ready", {63'd0, bus.res_ready}, 1);
        tick();
        cfg_len = 6'd1;
        send(1, 1);
        @(negedge clk);
        chk("mrst_re", bus.acc_re, 1);
        chk("mrst_im", bus.acc_im, 1);
        tick();
        drain();

        // randomized traffic, producer holds data until accepted
        last_acc = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.res_val || last_acc) begin
                bus.res_val = ($urandom_range(0, 3) != 0);
                bus.res_re  = RW'($urandom);
                bus.res_im  = RW'($urandom);
            end
            bus.acc_ready = $urandom_range(0, 1) == 1;
            cfg_len = ($urandom_range(0, 9) == 0) ? LW'($urandom) : LW'($urandom_range(0, 5));
            sw_rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            last_acc = bus.res_val && bus.res_ready;
            tick();
        end
        sw_rst = 1'b0; bus.res_val = 1'b0; bus.acc_ready = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/complex_nr_acc.md
Name: complex_nr_acc

Overview:
- Downstream consumer of the complex number multiplier.
- Accepts products over the res_val/res_ready handshake, accumulates a frame of cfg_len products into a complex sum (complex dot product), then presents the sum on an output valid/ready handshake.
- Turns the multiplier into a complex MAC stage for downstream filtering logic.

Parameters:
- DATA_WIDTH, 8, operand width of the multiplier.
- RES_WIDTH, 2*DATA_WIDTH+1, signed width of each product component.
- LEN_WIDTH, 6, width of the frame length field (max frame 2^LEN_WIDTH-1).
- ACC_WIDTH, RES_WIDTH+LEN_WIDTH, signed accumulator width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- sw_rst  input  1  synchronous reset, active-high; the only reset.
- cfg_len  input  LEN_WIDTH  products per frame, unsigned; sampled on first product of a frame.
- res_val  input  1  product valid from multiplier.
- res_ready  output  1  accumulator can take a product.
- res_re  input  RES_WIDTH  product real part, signed two's complement.
- res_im  input  RES_WIDTH  product imaginary part, signed.
- acc_val  output  1  frame sum valid.
- acc_ready  input  1  consumer takes the sum.
- acc_re  output  ACC_WIDTH  sum real part, signed.
- acc_im  output  ACC_WIDTH  sum imaginary part, signed.
- acc_ovf  output  1  sticky overflow flag for the current frame, valid with acc_val.
- frame_cnt  output  LEN_WIDTH  products accepted in the current frame.

Behaviour:
- Reset (sw_rst=1 at posedge): state=ACC, acc_re=acc_im=0, acc_ovf=0, frame_cnt=0, acc_val=0. res_ready is 0 during the reset cycle and 1 afterwards. Reset mid-frame or mid-output discards all partial or pending results.
- Product handshake: a transfer occurs on a posedge with res_val=1 and res_ready=1. res_ready is registered-state based (1 in ACC, 0 in OUT) and never depends combinationally on res_val.
- States:
  - ACC: res_ready=1, acc_val=0.
    - On handshake with frame_cnt==0: len_q<=max(cfg_len,1), acc<=sign-extended product, acc_ovf<=0.
    - Otherwise: acc<=acc+sign-extended product.
    - frame_cnt increments on each handshake.
    - When the handshake brings frame_cnt to len_q, go to OUT.
  - OUT: acc_val=1, res_ready=0; acc_re/acc_im/acc_ovf held stable.
    - On acc_ready=1 at posedge: acc_val deasserts, frame_cnt<=0, go to ACC.
    - acc_re/acc_im keep the last value until the next frame's first product overwrites them.
- Latency:
  - acc_val rises the cycle after the last product handshake.
  - Minimum frame turnaround is len_q+1 cycles with acc_ready held 1.
  - Back-to-back products are accepted every cycle in ACC.
- Arithmetic:
  - Components add independently, two's-complement wrap at ACC_WIDTH.
  - acc_ovf sets when either addition has signed overflow (operand signs equal, result sign differs). It stays set until the next frame's first product.
- cfg_len=0 is treated as 1. cfg_len changes after the first product of a frame have no effect until the next frame.
- acc_ready=1 while acc_val=0 is ignored. res_val while in OUT is not accepted; the producer holds it (backpressure).

Decomposition:
- Shared package (complex_nr_pkg): DATA_WIDTH/RES_WIDTH defaults, state encoding constants ST_ACC=1'b0 and ST_OUT=1'b1.
- One natural sub-module: complex_nr_acc_add, a signed ACC_WIDTH adder with overflow flag, instantiated twice (re, im).
- The FSM and counter stay in the top.

Test Plan (DATA_WIDTH=8, LEN_WIDTH=6, ACC_WIDTH=23):
- Reset then cfg_len=1, product (-10,+20) [from (2+4i)(3+4i)] -> acc_val next cycle, acc=(-10,20), acc_ovf=0, frame_cnt=1.
- cfg_len=3, three back-to-back products (-10,20) with acc_ready=1 -> res_ready high for 3 cycles, acc_val one cycle after the third, acc=(-30,60), then ACC with frame_cnt=0.
- Backpressure: frame done with acc_ready=0 for 5 cycles, res_val=1 with (7,7) -> res_ready=0 and acc_val=1 held, acc stable. When acc_ready=1, the next frame starts and (7,7) is accepted the cycle after.
- cfg_len=0 with product (5,-5) -> treated as 1: acc=(5,-5) after one product.
- Overflow: cfg_len=63, 63 products of (32767,-32768) -> no overflow (max 2064321 < 2^22), acc=(2064321,-2064384). Then force a wrap by preloading via a direct adder unit test on complex_nr_acc_add -> acc_ovf=1.
- sw_rst asserted after 2 of 3 products -> next cycle acc_val=0, frame_cnt=0, res_ready=1. A fresh 1-product frame of (1,1) yields acc=(1,1) with no residue.
